// File: rtl/z80_bus_ctrl_if.sv
// Bus-side signal bundle between the pad ring, the z80 core wrapper and the
// pad bus controller. The controller (master) consumes the raw pad inputs,
// the core's /BUSAK and data-write enable, and drives the synchronised core
// inputs, the core reset and all pad output-enable-bar signals.
interface z80_bus_ctrl_if;
  // Raw asynchronous Z80 control inputs from the pads
  logic pad_wait_n;
  logic pad_int_n;
  logic pad_nmi_n;
  logic pad_busrq_n;

  // Signals from the core, on the controller's clock
  logic core_busak_n;
  logic core_doe;

  // Signals towards the core
  logic core_reset_n;
  logic core_wait_n;
  logic core_int_n;
  logic core_nmi_n;
  logic core_busrq_n;

  // Pad output-enable-bar (1 = float) and status
  logic addr_oeb;
  logic ctrl_oeb;
  logic stat_oeb;
  logic data_oeb;
  logic bus_float;

  // Controller side
  modport master (
    input  pad_wait_n, pad_int_n, pad_nmi_n, pad_busrq_n,
    input  core_busak_n, core_doe,
    output core_reset_n, core_wait_n, core_int_n, core_nmi_n, core_busrq_n,
    output addr_oeb, ctrl_oeb, stat_oeb, data_oeb, bus_float
  );

  // Pad ring / core side
  modport slave (
    output pad_wait_n, pad_int_n, pad_nmi_n, pad_busrq_n,
    output core_busak_n, core_doe,
    input  core_reset_n, core_wait_n, core_int_n, core_nmi_n, core_busrq_n,
    input  addr_oeb, ctrl_oeb, stat_oeb, data_oeb, bus_float
  );
endinterface

// File: rtl/z80_bus_ctrl.sv
// Pad-side bus controller for the z80 core wrapper.
// - Synchronises /WAIT, /INT, /NMI and /BUSRQ from the pads.
// - Stretches the core reset for RST_HOLD cycles and releases it synchronously.
// - Floats address/control pads during reset and bus grant, with a
//   TURN_CYCLES dead time before the pads are driven again after /BUSAK
//   releases. Status pads float only while the core is held in reset.
module z80_bus_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int RST_HOLD    = 4,
  parameter int TURN_CYCLES = 1
) (
  input  logic           wb_clk_i,
  input  logic           rst_n,
  z80_bus_ctrl_if.master bus
);

  // Counter sized to hold the larger of the two terminal counts
  localparam int CNT_MAX = (RST_HOLD > TURN_CYCLES) ? RST_HOLD : TURN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'((TURN_CYCLES > 0) ? (TURN_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    DRIVE = 2'd1,
    FLOAT = 2'd2,
    TURN  = 2'd3
  } state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [CNT_W-1:0]                cnt_inc;

  // One synchroniser chain per pad input: [0]=wait [1]=int [2]=nmi [3]=busrq
  logic [3:0]                      pad_in;
  logic [3:0][SYNC_STAGES-1:0]     sync_q, sync_d;

  logic                            core_reset_n_q, core_reset_n_d;
  logic                            float_q, float_d;
  logic                            stat_oeb_q, stat_oeb_d;

  assign pad_in = {bus.pad_busrq_n, bus.pad_nmi_n, bus.pad_int_n, bus.pad_wait_n};

  // Shift each pad input one stage further down its synchroniser chain
  always_comb begin
    sync_d = sync_q;
    for (int i = 0; i < 4; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], pad_in[i]};
    end
  end

  // Counter never wraps: it parks at all-ones if ever left running
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : (cnt_q + CNT_W'(1));

  // Next-state, counter and registered-output decode for the pad FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;

    case (state_q)
      HOLD: begin
        cnt_d = cnt_inc;
        if (cnt_q == HOLD_LAST) begin
          state_d = DRIVE;
        end
      end

      DRIVE: begin
        if (!bus.core_busak_n) begin
          state_d = FLOAT;
        end
      end

      FLOAT: begin
        if (bus.core_busak_n) begin
          state_d = (TURN_CYCLES > 0) ? TURN : DRIVE;
        end
      end

      TURN: begin
        cnt_d = cnt_inc;
        // A fresh bus grant always wins over the dead-time count
        if (!bus.core_busak_n) begin
          state_d = FLOAT;
        end else if (cnt_q == TURN_LAST) begin
          state_d = DRIVE;
        end
      end

      default: begin
        state_d = HOLD;
      end
    endcase

    // Every state is entered with a clean count
    if (state_d != state_q) begin
      cnt_d = '0;
    end

    // Registered outputs follow the state being entered, so they change on
    // the same edge as the state itself. Core reset is only ever asserted by
    // rst_n; once the FSM has left HOLD it stays released.
    core_reset_n_d = (state_d != HOLD);
    float_d        = (state_d != DRIVE);
    stat_oeb_d     = (state_d == HOLD);
  end

  // State, counter, synchroniser and output registers
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= HOLD;
      cnt_q          <= '0;
      sync_q         <= '1;
      core_reset_n_q <= 1'b0;
      float_q        <= 1'b1;
      stat_oeb_q     <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sync_q         <= sync_d;
      core_reset_n_q <= core_reset_n_d;
      float_q        <= float_d;
      stat_oeb_q     <= stat_oeb_d;
    end
  end

  assign bus.core_wait_n  = sync_q[0][SYNC_STAGES-1];
  assign bus.core_int_n   = sync_q[1][SYNC_STAGES-1];
  assign bus.core_nmi_n   = sync_q[2][SYNC_STAGES-1];
  assign bus.core_busrq_n = sync_q[3][SYNC_STAGES-1];

  assign bus.core_reset_n = core_reset_n_q;
  assign bus.addr_oeb     = float_q;
  assign bus.ctrl_oeb     = float_q;
  assign bus.bus_float    = float_q;
  assign bus.stat_oeb     = stat_oeb_q;

  // Data pads turn around combinationally with the core's write enable,
  // but only while the bus is actually being driven
  assign bus.data_oeb     = ~(bus.core_doe & ~float_q);

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// Scoreboard bench for z80_bus_ctrl. Two instances share all stimulus:
// u_dut uses TURN_CYCLES=1, u_dut_t0 uses TURN_CYCLES=0. Expected output
// values are queued with the cycle they are due and compared on the
// falling clock edge of that cycle.
module tb_z80_bus_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic pad_wait_n, pad_int_n, pad_nmi_n, pad_busrq_n;
  logic busak_n, doe;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int    due;
    string tag;
    int    sel;
    logic  exp;
  } sb_t;

  sb_t sb[$];
  sb_t cur;

  z80_bus_ctrl_if bus ();
  z80_bus_ctrl_if bus0 ();

  assign bus.pad_wait_n    = pad_wait_n;
  assign bus.pad_int_n     = pad_int_n;
  assign bus.pad_nmi_n     = pad_nmi_n;
  assign bus.pad_busrq_n   = pad_busrq_n;
  assign bus.core_busak_n  = busak_n;
  assign bus.core_doe      = doe;
  assign bus0.pad_wait_n   = pad_wait_n;
  assign bus0.pad_int_n    = pad_int_n;
  assign bus0.pad_nmi_n    = pad_nmi_n;
  assign bus0.pad_busrq_n  = pad_busrq_n;
  assign bus0.core_busak_n = busak_n;
  assign bus0.core_doe     = doe;

  z80_bus_ctrl #(.SYNC_STAGES(2), .RST_HOLD(4), .TURN_CYCLES(1)) u_dut (
    .wb_clk_i (clk),
    .rst_n    (rst_n),
    .bus      (bus.master)
  );

  z80_bus_ctrl #(.SYNC_STAGES(2), .RST_HOLD(4), .TURN_CYCLES(0)) u_dut_t0 (
    .wb_clk_i (clk),
    .rst_n    (rst_n),
    .bus      (bus0.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  localparam int S_RST   = 0;
  localparam int S_ADDR  = 1;
  localparam int S_CTRL  = 2;
  localparam int S_STAT  = 3;
  localparam int S_DATA  = 4;
  localparam int S_FLOAT = 5;
  localparam int S_WAIT  = 6;
  localparam int S_INT   = 7;
  localparam int S_NMI   = 8;
  localparam int S_BUSRQ = 9;
  localparam int S_ADDR0 = 10;
  localparam int S_DATA0 = 11;
  localparam int S_RST0  = 12;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic obs(input int sel);
    case (sel)
      S_RST:   return bus.core_reset_n;
      S_ADDR:  return bus.addr_oeb;
      S_CTRL:  return bus.ctrl_oeb;
      S_STAT:  return bus.stat_oeb;
      S_DATA:  return bus.data_oeb;
      S_FLOAT: return bus.bus_float;
      S_WAIT:  return bus.core_wait_n;
      S_INT:   return bus.core_int_n;
      S_NMI:   return bus.core_nmi_n;
      S_BUSRQ: return bus.core_busrq_n;
      S_ADDR0: return bus0.addr_oeb;
      S_DATA0: return bus0.data_oeb;
      S_RST0:  return bus0.core_reset_n;
      default: return 1'bx;
    endcase
  endfunction

  // Queue an expected value due dly rising edges from now, kept sorted by due cycle
  task automatic expect_at(input string tag, input int sel, input logic v, input int dly);
    sb_t e;
    int  idx;
    e.due = cyc + dly;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    idx   = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].due > e.due) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pad(input int i, input logic v);
    case (i)
      0: pad_wait_n  = v;
      1: pad_int_n   = v;
      2: pad_nmi_n   = v;
      default: pad_busrq_n = v;
    endcase
  endtask

  // Compare every expectation that has fallen due, away from the rising edge
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      cur = sb.pop_front();
      chk(cur.tag, {31'd0, obs(cur.sel)}, {31'd0, cur.exp});
    end
  end

  initial begin
    rst_n       = 1'b0;
    pad_wait_n  = 1'b1;
    pad_int_n   = 1'b1;
    pad_nmi_n   = 1'b1;
    pad_busrq_n = 1'b1;
    busak_n     = 1'b1;
    doe         = 1'b0;

    tick(2);

    // Reset values
    expect_at("rst_core_reset_n", S_RST,   1'b0, 0);
    expect_at("rst_addr_oeb",     S_ADDR,  1'b1, 0);
    expect_at("rst_ctrl_oeb",     S_CTRL,  1'b1, 0);
    expect_at("rst_stat_oeb",     S_STAT,  1'b1, 0);
    expect_at("rst_data_oeb",     S_DATA,  1'b1, 0);
    expect_at("rst_bus_float",    S_FLOAT, 1'b1, 0);
    expect_at("rst_wait_n",       S_WAIT,  1'b1, 0);
    expect_at("rst_int_n",        S_INT,   1'b1, 0);
    expect_at("rst_nmi_n",        S_NMI,   1'b1, 0);
    expect_at("rst_busrq_n",      S_BUSRQ, 1'b1, 0);
    expect_at("rst_t0_addr_oeb",  S_ADDR0, 1'b1, 0);

    // Reset release: core_reset_n and pad enables change exactly 4 edges later.
    // core_doe held high so data_oeb shows it is forced while in HOLD.
    doe   = 1'b1;
    rst_n = 1'b1;
    for (int d = 0; d < 4; d++) begin
      expect_at($sformatf("hold_core_reset_n_d%0d", d), S_RST,  1'b0, d);
      expect_at($sformatf("hold_addr_oeb_d%0d", d),     S_ADDR, 1'b1, d);
      expect_at($sformatf("hold_data_oeb_d%0d", d),     S_DATA, 1'b1, d);
    end
    expect_at("hold_stat_oeb_d3",  S_STAT,  1'b1, 3);
    expect_at("rel_core_reset_n",  S_RST,   1'b1, 4);
    expect_at("rel_addr_oeb",      S_ADDR,  1'b0, 4);
    expect_at("rel_ctrl_oeb",      S_CTRL,  1'b0, 4);
    expect_at("rel_stat_oeb",      S_STAT,  1'b0, 4);
    expect_at("rel_bus_float",     S_FLOAT, 1'b0, 4);
    expect_at("rel_data_oeb",      S_DATA,  1'b0, 4);
    expect_at("rel_t0_addr_oeb",   S_ADDR0, 1'b0, 4);
    expect_at("rel_t0_core_reset", S_RST0,  1'b1, 4);
    tick(5);
    doe = 1'b0;
    expect_at("drive_doe0_data_oeb", S_DATA, 1'b1, 0);
    tick(1);

    // Synchroniser latency, both directions, pads changed mid-cycle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_pad(i, 1'b0);
      expect_at($sformatf("sync%0d_fall_d1", i), S_WAIT + i, 1'b1, 1);
      expect_at($sformatf("sync%0d_fall_d2", i), S_WAIT + i, 1'b0, 2);
      tick(3);
      @(negedge clk);
      set_pad(i, 1'b1);
      expect_at($sformatf("sync%0d_rise_d1", i), S_WAIT + i, 1'b0, 1);
      expect_at($sformatf("sync%0d_rise_d2", i), S_WAIT + i, 1'b1, 2);
      tick(3);
    end

    // Data direction while driving: same-cycle response to core_doe
    doe = 1'b1;
    expect_at("dir_doe1_data_oeb", S_DATA, 1'b0, 0);
    tick(1);
    doe = 1'b0;
    expect_at("dir_doe0_data_oeb", S_DATA, 1'b1, 0);
    tick(1);
    doe = 1'b1;
    expect_at("dir_doe1b_data_oeb", S_DATA, 1'b0, 0);
    tick(1);

    // Bus grant: float one edge after /BUSAK is sampled low, status stays driven
    busak_n = 1'b0;
    expect_at("grant_addr_oeb_d0",  S_ADDR,  1'b0, 0);
    expect_at("grant_addr_oeb_d1",  S_ADDR,  1'b1, 1);
    expect_at("grant_ctrl_oeb_d1",  S_CTRL,  1'b1, 1);
    expect_at("grant_bus_float_d1", S_FLOAT, 1'b1, 1);
    expect_at("grant_data_oeb_d1",  S_DATA,  1'b1, 1);
    expect_at("grant_stat_oeb_d1",  S_STAT,  1'b0, 1);
    expect_at("grant_t0_addr_d1",   S_ADDR0, 1'b1, 1);
    expect_at("grant_addr_oeb_d2",  S_ADDR,  1'b1, 2);
    tick(3);

    // Release: TURN_CYCLES=1 re-drives at M+2, TURN_CYCLES=0 at M+1
    busak_n = 1'b1;
    expect_at("release_addr_oeb_d1",  S_ADDR,  1'b1, 1);
    expect_at("release_data_oeb_d1",  S_DATA,  1'b1, 1);
    expect_at("release_t0_addr_d1",   S_ADDR0, 1'b0, 1);
    expect_at("release_t0_data_d1",   S_DATA0, 1'b0, 1);
    expect_at("release_addr_oeb_d2",  S_ADDR,  1'b0, 2);
    expect_at("release_ctrl_oeb_d2",  S_CTRL,  1'b0, 2);
    expect_at("release_float_d2",     S_FLOAT, 1'b0, 2);
    expect_at("release_data_oeb_d2",  S_DATA,  1'b0, 2);
    expect_at("release_stat_oeb_d2",  S_STAT,  1'b0, 2);
    tick(3);

    // Turnaround abort: /BUSAK re-asserted while in TURN
    busak_n = 1'b0;
    tick(2);
    busak_n = 1'b1;
    tick(1);
    busak_n = 1'b0;
    expect_at("abort_t0_addr_d0", S_ADDR0, 1'b0, 0);
    expect_at("abort_addr_oeb_d1", S_ADDR, 1'b1, 1);
    expect_at("abort_t0_addr_d1", S_ADDR0, 1'b1, 1);
    expect_at("abort_addr_oeb_d2", S_ADDR, 1'b1, 2);
    tick(2);

    // /BUSAK toggling every cycle: TURN_CYCLES=1 never re-drives
    for (int k = 0; k < 6; k++) begin
      busak_n = (k % 2 == 0);
      expect_at($sformatf("toggle%0d_addr_oeb", k), S_ADDR, 1'b1, 1);
      expect_at($sformatf("toggle%0d_data_oeb", k), S_DATA, 1'b1, 1);
      expect_at($sformatf("toggle%0d_t0_addr", k), S_ADDR0, (k % 2 == 0) ? 1'b0 : 1'b1, 1);
      tick(1);
    end

    // Release into TURN, then reset mid-turnaround
    busak_n = 1'b1;
    expect_at("turn_addr_oeb_d1", S_ADDR, 1'b1, 1);
    tick(1);
    rst_n = 1'b0;
    expect_at("midrst_core_reset_n", S_RST,   1'b0, 0);
    expect_at("midrst_addr_oeb",     S_ADDR,  1'b1, 0);
    expect_at("midrst_ctrl_oeb",     S_CTRL,  1'b1, 0);
    expect_at("midrst_stat_oeb",     S_STAT,  1'b1, 0);
    expect_at("midrst_bus_float",    S_FLOAT, 1'b1, 0);
    expect_at("midrst_data_oeb",     S_DATA,  1'b1, 0);
    expect_at("midrst_t0_addr_oeb",  S_ADDR0, 1'b1, 0);
    expect_at("midrst_t0_core_rst",  S_RST0,  1'b0, 0);
    tick(2);

    // HOLD sequence reruns in full
    rst_n = 1'b1;
    expect_at("rerun_core_reset_d3", S_RST,  1'b0, 3);
    expect_at("rerun_addr_oeb_d3",   S_ADDR, 1'b1, 3);
    expect_at("rerun_core_reset_d4", S_RST,  1'b1, 4);
    expect_at("rerun_addr_oeb_d4",   S_ADDR, 1'b0, 4);
    expect_at("rerun_stat_oeb_d4",   S_STAT, 1'b0, 4);
    tick(6);

    // Bounded drain of any outstanding expectations
    for (int w = 0; w < 10 && sb.size() != 0; w++) begin
      tick(1);
    end
    if (sb.size() != 0) begin
      chk("sb_drain", sb.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
